// File: rtl/wb_post_wr_buf.sv
// wb_post_wr_buf: Wishbone posted-write buffer placed in front of a RAM slave.
// Upstream writes are acked as soon as they land in a small FIFO. They are
// then replayed downstream in order. An upstream read waits until the FIFO
// has drained and the downstream side is idle, so it always observes every
// earlier write.
// Optional status ports level_o / ovf_stall_o: define WB_POST_WR_BUF_STATUS_EN.
// depth_log2 must be at least 1.
module wb_post_wr_buf #(
  parameter int adr_width  = 12,
  parameter int depth_log2 = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // upstream slave side
  input  logic [31:0]          s_dat_i,
  output logic [31:0]          s_dat_o,
  input  logic [adr_width-1:2] s_adr_i,
  input  logic                 s_we_i,
  input  logic [3:0]           s_sel_i,
  input  logic                 s_cyc_i,
  input  logic                 s_stb_i,
  input  logic [2:0]           s_cti_i,
  output logic                 s_ack_o,
  // downstream master side
  output logic [31:0]          m_dat_o,
  input  logic [31:0]          m_dat_i,
  output logic [adr_width-1:2] m_adr_o,
  output logic                 m_we_o,
  output logic [3:0]           m_sel_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic [2:0]           m_cti_o,
  input  logic                 m_ack_i
`ifdef WB_POST_WR_BUF_STATUS_EN
  ,
  output logic [depth_log2:0]  level_o,
  output logic                 ovf_stall_o
`endif
);

  localparam int DEPTH = 2 ** depth_log2;
  localparam logic [depth_log2-1:0] PTR_ZERO = {depth_log2{1'b0}};
  localparam logic [depth_log2-1:0] PTR_ONE  = {{(depth_log2-1){1'b0}}, 1'b1};
  localparam logic [depth_log2:0]   CNT_ZERO = {(depth_log2+1){1'b0}};
  localparam logic [depth_log2:0]   CNT_ONE  = {{depth_log2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10
  } state_t;

  state_t                state_r;
  logic [adr_width-1:2]  adr_mem [DEPTH];
  logic [3:0]            sel_mem [DEPTH];
  logic [31:0]           dat_mem [DEPTH];
  logic [depth_log2-1:0] wptr_r;
  logic [depth_log2-1:0] rptr_r;
  logic [depth_log2:0]   count_r;
  logic                  rd_live_r;

  logic full_s;
  logic empty_s;
  logic rd_hold_s;
  logic wr_req_s;
  logic rd_req_s;
  logic push_s;
  logic pop_s;
  logic rd_done_s;
  logic rd_fwd_s;

  // Cycle type tags carry no meaning for a single-beat RAM bridge.
  logic unused_cti_s;
  assign unused_cti_s = ^s_cti_i;

  // The count saturates at exactly DEPTH, so its top bit alone flags full.
  assign full_s    = count_r[depth_log2];
  assign empty_s   = (count_r == CNT_ZERO);
  // An upstream read is still being presented (used to detect abandonment).
  assign rd_hold_s = s_cyc_i & s_stb_i & ~s_we_i;
  // The ack cycle itself never starts a new transfer: one strobe, one push.
  assign wr_req_s  = s_cyc_i & s_stb_i & s_we_i & ~s_ack_o;
  assign rd_req_s  = rd_hold_s & ~s_ack_o;
  assign push_s    = wr_req_s & ~full_s;
  assign pop_s     = (state_r == ST_WR) & m_ack_i;
  assign rd_done_s = (state_r == ST_RD) & m_ack_i;
  // Only forward read data if the requester stayed on the bus throughout.
  assign rd_fwd_s  = rd_done_s & rd_live_r & rd_hold_s;

  assign m_cti_o   = 3'b000;

`ifdef WB_POST_WR_BUF_STATUS_EN
  // count_r is already a register, so level_o is a registered occupancy.
  assign level_o     = count_r;
  // Flags every cycle a presented write is held back by a full FIFO.
  assign ovf_stall_o = wr_req_s & full_s;
`endif

  // FIFO bookkeeping: pointers wrap at 2**depth_log2, count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wptr_r  <= PTR_ZERO;
      rptr_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) wptr_r <= wptr_r + PTR_ONE;
      if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; entries are only read while valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      adr_mem[wptr_r] <= s_adr_i;
      sel_mem[wptr_r] <= s_sel_i;
      dat_mem[wptr_r] <= s_dat_i;
    end
  end

  // Upstream response: one-cycle ack for accepted writes and forwarded reads.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s_ack_o <= 1'b0;
      s_dat_o <= 32'h0000_0000;
    end else begin
      s_ack_o <= push_s | rd_fwd_s;
      if (rd_done_s) s_dat_o <= m_dat_i;
    end
  end

  // Downstream sequencer: drains the FIFO first, then issues a waiting read.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_adr_o   <= {(adr_width-2){1'b0}};
      m_sel_o   <= 4'h0;
      m_dat_o   <= 32'h0000_0000;
      rd_live_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            state_r <= ST_WR;
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b1;
            m_adr_o <= adr_mem[rptr_r];
            m_sel_o <= sel_mem[rptr_r];
            m_dat_o <= dat_mem[rptr_r];
          end else if (rd_req_s) begin
            state_r   <= ST_RD;
            m_cyc_o   <= 1'b1;
            m_stb_o   <= 1'b1;
            m_we_o    <= 1'b0;
            m_adr_o   <= s_adr_i;
            m_sel_o   <= s_sel_i;
            rd_live_r <= 1'b1;
          end
        end
        ST_WR: begin
          if (m_ack_i) begin
            state_r <= ST_IDLE;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
          end
        end
        ST_RD: begin
          if (m_ack_i) begin
            state_r   <= ST_IDLE;
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            rd_live_r <= 1'b0;
          end else if (!rd_hold_s) begin
            // Requester walked away: finish downstream but drop the result.
            rd_live_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          m_cyc_o   <= 1'b0;
          m_stb_o   <= 1'b0;
          m_we_o    <= 1'b0;
          rd_live_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_post_wr_buf.sv
// Self-checking bench for wb_post_wr_buf: a RAM slave model on the downstream
// side records every downstream transfer; a word-level reference memory on
// the upstream side predicts read data and the ordered downstream write list.
module tb_wb_post_wr_buf;

  localparam int AW = 12;
  localparam int DL = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [31:0]   s_dat_i = 32'h0;
  logic [31:0]   s_dat_o;
  logic [AW-1:2] s_adr_i = '0;
  logic          s_we_i = 1'b0;
  logic [3:0]    s_sel_i = 4'h0;
  logic          s_cyc_i = 1'b0;
  logic          s_stb_i = 1'b0;
  logic [2:0]    s_cti_i = 3'b000;
  logic          s_ack_o;
  logic [31:0]   m_dat_o;
  logic [31:0]   m_dat_i;
  logic [AW-1:2] m_adr_o;
  logic          m_we_o;
  logic [3:0]    m_sel_o;
  logic          m_cyc_o;
  logic          m_stb_o;
  logic [2:0]    m_cti_o;
  logic          m_ack_i = 1'b0;
`ifdef WB_POST_WR_BUF_STATUS_EN
  logic [DL:0]   level_o;
  logic          ovf_stall_o;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [9:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } txn_t;

  txn_t        dn_q[$];        // downstream transfers seen by the RAM model
  txn_t        exp_q[$];       // writes the bench expects downstream, in order
  logic [31:0] ram [1024];     // downstream RAM contents
  logic [31:0] ref_mem [1024]; // upstream view: latest acked write per word
  bit          ack_block = 1'b1;
  bit          ram_clr = 1'b1;
  int          wait_cnt = 0;
  int          cur_lat = 0;

  wb_post_wr_buf #(.adr_width(AW), .depth_log2(DL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_adr_i(s_adr_i), .s_we_i(s_we_i),
    .s_sel_i(s_sel_i), .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_cti_i(s_cti_i),
    .s_ack_o(s_ack_o),
    .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_adr_o(m_adr_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_cti_o(m_cti_o),
    .m_ack_i(m_ack_i)
`ifdef WB_POST_WR_BUF_STATUS_EN
    , .level_o(level_o), .ovf_stall_o(ovf_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    merge = old;
    for (int b = 0; b < 4; b++) if (sel[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  // RAM slave: acks after a random 0..3 cycle wait unless ack_block is set.
  assign m_dat_i = m_ack_i ? ram[m_adr_o] : 32'h0;
  always @(posedge clk_i) begin
    if (ram_clr) for (int k = 0; k < 1024; k++) ram[k] <= 32'h0;
    if (!rst_i || m_ack_i) begin
      m_ack_i  <= 1'b0;
      wait_cnt <= 0;
    end else if (m_cyc_o && m_stb_o && !ack_block) begin
      if (wait_cnt >= cur_lat) begin
        m_ack_i  <= 1'b1;
        wait_cnt <= 0;
        cur_lat  <= $urandom_range(0, 3);
        dn_q.push_back('{we: m_we_o, adr: m_adr_o, sel: m_sel_o, dat: m_dat_o});
        if (m_we_o) ram[m_adr_o] <= merge(ram[m_adr_o], m_dat_o, m_sel_o);
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Upstream write; holds the strobe through the ack cycle.
  task automatic do_write(input logic [9:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                          input bit commit, output int lat);
    txn_t t;
    s_adr_i = adr; s_sel_i = sel; s_dat_i = dat; s_we_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    lat = 0;
    do begin @(posedge clk_i); #1; lat++; end while (s_ack_o !== 1'b1 && lat < 300);
    checks++;
    if (s_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL write_ack_timeout adr=%h no ack after %0d cycles", adr, lat);
    end else begin
      if (commit) begin
        t = '{we: 1'b1, adr: adr, sel: sel, dat: dat};
        exp_q.push_back(t);
        ref_mem[adr] = merge(ref_mem[adr], dat, sel);
      end
      @(posedge clk_i); #1;
      checks++;
      if (s_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL write_ack_width adr=%h s_ack_o=%b required 0", adr, s_ack_o);
      end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  // Upstream read; returns the data seen with the ack.
  task automatic do_read(input logic [9:0] adr, input logic [3:0] sel, output logic [31:0] dat);
    int n;
    s_adr_i = adr; s_sel_i = sel; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    n = 0; dat = 32'h0;
    do begin @(posedge clk_i); #1; n++; end while (s_ack_o !== 1'b1 && n < 300);
    checks++;
    if (s_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL read_ack_timeout adr=%h no ack after %0d cycles", adr, n);
    end else begin
      dat = s_dat_o;
      @(posedge clk_i); #1;
      checks++;
      if (s_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL read_ack_width adr=%h s_ack_o=%b required 0", adr, s_ack_o);
      end
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 1024; k++) ref_mem[k] = 32'h0;
    rst_i = 1'b0;
    settle(3);
    ram_clr = 1'b0;
    checks++;
    if ({s_ack_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o, m_cti_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ack=%b sdat=%h cyc=%b stb=%b we=%b adr=%h sel=%h mdat=%h cti=%h required all 0",
               s_ack_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o, m_cti_o);
    end
`ifdef WB_POST_WR_BUF_STATUS_EN
    checks++;
    if (level_o !== '0) begin failures++; $display("FAIL reset_level got=%0d required 0", level_o); end
`endif
    rst_i = 1'b1;
    ack_block = 1'b0;
    settle(2);
  endtask

  task automatic test_single_write();
    int lat;
    dn_q.delete(); exp_q.delete();
    do_write(10'h004, 4'hF, 32'hDEADBEEF, 1'b1, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL single_ack_latency got=%0d required 1", lat); end
`ifdef WB_POST_WR_BUF_STATUS_EN
    checks++;
    if (level_o !== 3'd1) begin failures++; $display("FAIL single_level_busy got=%0d required 1", level_o); end
`endif
    settle(20);
    checks++;
    if (dn_q.size() !== 1 || dn_q[0] !== {1'b1, 10'h004, 4'hF, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL single_downstream count=%0d first=%h required one write 1/004/f/deadbeef",
               dn_q.size(), dn_q.size() > 0 ? dn_q[0] : '0);
    end
`ifdef WB_POST_WR_BUF_STATUS_EN
    checks++;
    if (level_o !== 3'd0) begin failures++; $display("FAIL single_level_idle got=%0d required 0", level_o); end
`endif
  endtask

  task automatic test_byte_write();
    int lat; logic [31:0] r;
    dn_q.delete(); exp_q.delete();
    do_write(10'h030, 4'hF, 32'h11223344, 1'b1, lat);
    do_write(10'h030, 4'b0010, 32'h0000AB00, 1'b1, lat);
    settle(20);
    checks++;
    if (dn_q.size() !== 2 || dn_q[1].sel !== 4'b0010 || dn_q[1].dat !== 32'h0000AB00) begin
      failures++;
      $display("FAIL byte_downstream count=%0d sel=%b dat=%h required 2 writes, sel 0010 dat 0000ab00",
               dn_q.size(), dn_q.size() > 1 ? dn_q[1].sel : 4'h0, dn_q.size() > 1 ? dn_q[1].dat : 32'h0);
    end
    do_read(10'h030, 4'hF, r);
    checks++;
    if (r !== 32'h1122AB44) begin failures++; $display("FAIL byte_readback got=%h required 1122ab44", r); end
  endtask

  task automatic test_read_after_write();
    int lat; logic [31:0] r;
    dn_q.delete(); exp_q.delete();
    do_write(10'h008, 4'hF, 32'h12345678, 1'b1, lat);
    do_read(10'h008, 4'hF, r);
    checks++;
    if (r !== 32'h12345678) begin failures++; $display("FAIL raw_data got=%h required 12345678", r); end
    checks++;
    if (dn_q.size() !== 2 || dn_q[0].we !== 1'b1 || dn_q[1].we !== 1'b0 || dn_q[1].adr !== 10'h008) begin
      failures++;
      $display("FAIL raw_order count=%0d required write then read of 008", dn_q.size());
    end
  endtask

  task automatic test_overflow();
    int lat; int ka; int ks; bit stall_ok; int wi;
    logic [31:0] d [5]; logic [9:0] a; txn_t t;
    dn_q.delete(); exp_q.delete();
    ack_block = 1'b1;
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      a = 10'h040 + 10'(i);
      do_write(a, 4'hF, d[i], 1'b1, lat);
      checks++;
      if (lat !== 1) begin failures++; $display("FAIL ovf_fill_latency entry=%0d got=%0d required 1", i, lat); end
    end
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_cti_o} !== {3'b111, 10'h040, d[0], 3'b000}) begin
      failures++;
      $display("FAIL ovf_head cyc=%b stb=%b we=%b adr=%h dat=%h cti=%h required 111/040/%h/0",
               m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_cti_o, d[0]);
    end
    s_adr_i = 10'h044; s_sel_i = 4'hF; s_dat_i = d[4]; s_we_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    stall_ok = 1'b1;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (s_ack_o !== 1'b0) stall_ok = 1'b0;
`ifdef WB_POST_WR_BUF_STATUS_EN
      if (ovf_stall_o !== 1'b1) stall_ok = 1'b0;
`endif
    end
    checks++;
    if (!stall_ok) begin failures++; $display("FAIL ovf_stall ack/stall flag wrong while full, required ack 0"); end
    ack_block = 1'b0;
    ka = -1; ks = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk_i); #1;
      if (m_ack_i === 1'b1 && ka < 0) ka = c;
      if (s_ack_o === 1'b1) begin ks = c; break; end
    end
    checks++;
    if (ka < 0 || ks !== ka + 2) begin
      failures++;
      $display("FAIL ovf_release_ack m_ack_cycle=%0d s_ack_cycle=%0d required s_ack two cycles after m_ack", ka, ks);
    end
    if (ks > 0) begin
      t = '{we: 1'b1, adr: 10'h044, sel: 4'hF, dat: d[4]};
      exp_q.push_back(t);
      ref_mem[10'h044] = d[4];
    end
    @(posedge clk_i); #1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    settle(60);
    wi = 0;
    foreach (dn_q[k]) if (dn_q[k].we) begin
      checks++;
      if (wi >= exp_q.size() || dn_q[k] !== exp_q[wi]) begin
        failures++; $display("FAIL ovf_order idx=%0d got=%h", wi, dn_q[k]);
      end
      wi++;
    end
    checks++;
    if (wi !== exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d required %0d", wi, exp_q.size()); end
  endtask

  task automatic test_random();
    logic [9:0] a; logic [3:0] sel; logic [31:0] d; logic [31:0] r; int lat; int wi;
    dn_q.delete(); exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      a = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) begin
        sel = 4'($urandom_range(1, 15));
        d = $urandom;
        do_write(a, sel, d, 1'b1, lat);
      end else begin
        do_read(a, 4'hF, r);
        checks++;
        if (r !== ref_mem[a]) begin failures++; $display("FAIL rand_read adr=%h got=%h required %h", a, r, ref_mem[a]); end
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end
    settle(60);
    wi = 0;
    foreach (dn_q[k]) if (dn_q[k].we) begin
      checks++;
      if (wi >= exp_q.size() || dn_q[k] !== exp_q[wi]) begin
        failures++; $display("FAIL rand_write_order idx=%0d got=%h", wi, dn_q[k]);
      end
      wi++;
    end
    checks++;
    if (wi !== exp_q.size()) begin failures++; $display("FAIL rand_write_count got=%0d required %0d", wi, exp_q.size()); end
  endtask

  task automatic test_abandon();
    int lat; bit no_ack; int reads;
    // Read stalled behind two writes, then withdrawn before issue.
    dn_q.delete(); exp_q.delete();
    ack_block = 1'b1;
    do_write(10'h050, 4'hF, $urandom, 1'b1, lat);
    do_write(10'h051, 4'hF, $urandom, 1'b1, lat);
    s_adr_i = 10'h050; s_sel_i = 4'hF; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    no_ack = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; if (s_ack_o !== 1'b0) no_ack = 1'b0; end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    ack_block = 1'b0;
    repeat (30) begin @(posedge clk_i); #1; if (s_ack_o !== 1'b0) no_ack = 1'b0; end
    reads = 0;
    foreach (dn_q[k]) if (!dn_q[k].we) reads++;
    checks++;
    if (!no_ack || reads !== 0 || dn_q.size() !== 2) begin
      failures++;
      $display("FAIL abandon_stalled ack_seen=%b reads=%0d transfers=%0d required no ack, 0 reads, 2 writes",
               !no_ack, reads, dn_q.size());
    end
    // Read already issued downstream, then withdrawn: completes but is not acked upstream.
    dn_q.delete();
    ack_block = 1'b1;
    s_adr_i = 10'h055; s_sel_i = 4'h3; s_we_i = 1'b0; s_cyc_i = 1'b1; s_stb_i = 1'b1;
    settle(2);
    checks++;
    if ({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o} !== {3'b110, 10'h055, 4'h3}) begin
      failures++;
      $display("FAIL abandon_issue cyc=%b stb=%b we=%b adr=%h sel=%h required 110/055/3",
               m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o);
    end
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    ack_block = 1'b0;
    no_ack = 1'b1;
    repeat (20) begin @(posedge clk_i); #1; if (s_ack_o !== 1'b0) no_ack = 1'b0; end
    checks++;
    if (!no_ack || dn_q.size() !== 1 || dn_q[0].we !== 1'b0) begin
      failures++;
      $display("FAIL abandon_inflight ack_seen=%b transfers=%0d required one read, no ack", !no_ack, dn_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit idle_ok;
    dn_q.delete(); exp_q.delete();
    ack_block = 1'b1;
    for (int i = 0; i < 3; i++) do_write(10'h060 + 10'(i), 4'hF, $urandom, 1'b0, lat);
    checks++;
    if (m_stb_o !== 1'b1) begin failures++; $display("FAIL midrst_busy m_stb_o=%b required 1", m_stb_o); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({s_ack_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs ack=%b sdat=%h cyc=%b stb=%b we=%b adr=%h sel=%h mdat=%h required all 0",
               s_ack_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o, m_dat_o);
    end
    rst_i = 1'b1;
    ack_block = 1'b0;
    idle_ok = 1'b1;
    repeat (20) begin @(posedge clk_i); #1; if (m_cyc_o !== 1'b0) idle_ok = 1'b0; end
    checks++;
    if (!idle_ok || dn_q.size() !== 0) begin
      failures++;
      $display("FAIL midrst_discard cyc_seen=%b transfers=%0d required none", !idle_ok, dn_q.size());
    end
`ifdef WB_POST_WR_BUF_STATUS_EN
    checks++;
    if (level_o !== '0) begin failures++; $display("FAIL midrst_level got=%0d required 0", level_o); end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_single_write();
    test_byte_write();
    test_read_after_write();
    test_overflow();
    test_random();
    test_abandon();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/wb_post_wr_buf.md
WB_POST_WR_BUF -- requirements
Module: wb_post_wr_buf

Interface
REQ-001 SHALL have parameter adr_width, default 12, byte-address width shared with downstream RAM slave.
REQ-002 SHALL have parameter depth_log2, default 2, giving a posted-write FIFO depth of 2**depth_log2 entries.
REQ-003 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, synchronous, active-low.
REQ-004 SHALL have upstream slave ports: s_dat_i in 32; s_dat_o out 32; s_adr_i in [adr_width-1:2]; s_we_i in 1; s_sel_i in 4; s_cyc_i in 1; s_stb_i in 1; s_cti_i in 3 (ignored); s_ack_o out 1.
REQ-005 SHALL have downstream master ports: m_dat_o out 32; m_dat_i in 32; m_adr_o out [adr_width-1:2]; m_we_o out 1; m_sel_o out 4; m_cyc_o out 1; m_stb_o out 1; m_cti_o out 3; m_ack_i in 1.

Function
REQ-006 SHALL accept an upstream write (s_cyc_i & s_stb_i & s_we_i, s_ack_o low) when FIFO not full, pushing {adr, sel, dat} and asserting s_ack_o for exactly one cycle on the next edge.
REQ-007 SHALL hold s_ack_o low while the FIFO is full; the write is acked on the edge after an entry frees.
REQ-008 SHALL keep s_ack_o low for at least one cycle after every ack; no second push from one held strobe.
REQ-009 SHALL stall an upstream read until FIFO empty and downstream FSM IDLE, then issue it downstream; read-after-write ordering is preserved.
REQ-010 SHALL register m_dat_i into s_dat_o on m_ack_i of a read and assert s_ack_o one cycle later for one cycle.
REQ-011 SHALL run downstream FSM IDLE -> WR (FIFO non-empty) or RD (pending read, FIFO empty); WR/RD -> IDLE on m_ack_i; writes have priority over reads.
REQ-012 SHALL, in WR, drive m_cyc_o=m_stb_o=m_we_o=1 with head entry on m_adr_o/m_sel_o/m_dat_o, popping on m_ack_i.
REQ-013 SHALL, in RD, drive m_cyc_o=m_stb_o=1, m_we_o=0, m_sel_o=s_sel_i, m_adr_o=s_adr_i.
REQ-014 SHALL register all m_* outputs; m_stb_o/m_cyc_o drop the edge after m_ack_i; m_cti_o constant 3'b000.
REQ-015 SHALL allow push and pop in the same cycle; occupancy unchanged; full/empty computed from registered count.
REQ-016 SHALL wrap read/write pointers modulo 2**depth_log2.
REQ-017 SHALL abandon a stalled upstream read if s_cyc_i or s_stb_i drops before issue; a read already in RD completes downstream, its ack is not forwarded.

Reset
REQ-018 SHALL, on rst_i low at a clock edge, clear FIFO (pointers, count 0), FSM to IDLE, s_ack_o=0, s_dat_o=0, m_cyc_o=m_stb_o=m_we_o=0, m_adr_o=0, m_sel_o=0, m_dat_o=0.
REQ-019 SHALL discard buffered writes and any in-flight downstream transaction on reset mid-operation.

Configuration
REQ-020 SHALL, with WB_POST_WR_BUF_STATUS_EN defined, add outputs level_o [depth_log2:0] (registered occupancy, reset 0) and ovf_stall_o 1 (high each cycle a write is stalled by full).
REQ-021 SHALL, without WB_POST_WR_BUF_STATUS_EN, omit both ports; functional behaviour identical.

Verification
REQ-022 Single write adr 0x10, dat 0xDEADBEEF, sel 4'hF -> s_ack_o 1 cycle after strobe; downstream write same values; level_o 1 then 0.
REQ-023 Five back-to-back writes, depth 4, m_ack_i held off -> 4 acks, 5th stalled with ovf_stall_o=1 until first m_ack_i, then acked next edge.
REQ-024 Write 0x12345678 to adr 0x20 then immediate read adr 0x20, RAM model -> read issued only after write pop; s_dat_o=0x12345678.
REQ-025 Byte write sel 4'b0010 dat 0x0000AB00 -> m_sel_o=4'b0010, m_dat_o=0x0000AB00.
REQ-026 rst_i low with 3 buffered writes and m_stb_o high -> next edge all outputs at reset values, no further downstream writes.
REQ-027 Read stalled behind 2 writes, s_stb_i dropped -> no downstream read, no s_ack_o.
